// File: rtl/syn_sram_ctrl.sv
// syn_sram_ctrl: round-robin multi-port controller for an asynchronous SRAM.
// One access at a time; each access walks IDLE -> SETUP -> ACCESS (WAIT_CYCLES
// cycles) -> DONE. All pin-level outputs come straight from flops.
module syn_sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int NUM_PORTS   = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                            clk_ir,
  input  logic                            rst_ih,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            wr_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]     wdata_i,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] be_i,
  output logic [NUM_PORTS-1:0]            ack_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic [NUM_PORTS-1:0]            rdata_valid_o,
  inout  wire  [DATA_W-1:0]               sram_dq,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic [DATA_W/8-1:0]             sram_be_n,
  output logic                            sram_ce_n,
  output logic                            sram_oe_n,
  output logic                            sram_we_n
);

  localparam int LANES = DATA_W / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("syn_sram_ctrl: WAIT_CYCLES must be at least 1");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data
    $error("syn_sram_ctrl: DATA_W must be a non-zero multiple of 8");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
    $error("syn_sram_ctrl: NUM_PORTS must be in 1..8");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  // Per-port views of the packed command buses.
  logic [ADDR_W-1:0] port_addr  [NUM_PORTS];
  logic [DATA_W-1:0] port_wdata [NUM_PORTS];
  logic [LANES-1:0]  port_be    [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign port_addr[p]  = addr_i[p*ADDR_W +: ADDR_W];
    assign port_wdata[p] = wdata_i[p*DATA_W +: DATA_W];
    assign port_be[p]    = be_i[p*LANES +: LANES];
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]    be_q, be_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [LANES-1:0]    be_n_q, be_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                sel_found;
  logic [PW-1:0]       sel_idx;
  int                  scan_idx;

  // Round-robin pick: first requester at or above the pointer, wrapping round.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
      if (!sel_found && req_i[PW'(scan_idx)]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(scan_idx);
      end
    end
  end

  // Next-state logic plus the next value of every registered pin.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_SETUP;
          gnt_d   = sel_idx;
          ptr_d   = (int'(sel_idx) == NUM_PORTS - 1) ? '0 : PW'(int'(sel_idx) + 1);
          wr_d    = wr_i[sel_idx];
          addr_d  = port_addr[sel_idx];
          wdata_d = port_wdata[sel_idx];
          be_d    = port_be[sel_idx];
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CW'(WAIT_CYCLES - 1);
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          // Last strobe cycle: the SRAM output has had the full access time.
          if (!wr_q) rdata_d = sram_dq;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pins follow the state being entered so they are valid from its first edge.
    ce_n_d   = (state_d == S_IDLE);
    oe_n_d   = !((state_d == S_ACCESS) && !wr_d);
    we_n_d   = !((state_d == S_ACCESS) && wr_d);
    dq_oe_d  = (state_d != S_IDLE) && wr_d;
    be_n_d   = (state_d == S_IDLE) ? '1 : (wr_d ? ~be_d : '0);
    ack_d    = '0;
    rvalid_d = '0;
    if (state_d == S_DONE) begin
      ack_d[gnt_d] = 1'b1;
      if (!wr_d) rvalid_d[gnt_d] = 1'b1;
    end
  end

  // State and pin registers; reset drops the bus to idle at once.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    // NOTE: every register here, pins included, is reset so an aborted access leaves the bus quiet.
    if (rst_ih) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= '1;
      dq_oe_q  <= 1'b0;
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      dq_oe_q  <= dq_oe_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign sram_dq       = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr     = addr_q;
  assign sram_be_n     = be_n_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign ack_o         = ack_q;
  assign rdata_valid_o = rvalid_q;
  assign rdata_o       = rdata_q;

endmodule

// File: tb/tb_syn_sram_ctrl.sv
// Bench for syn_sram_ctrl: two instances (1 and 3 wait cycles) share the
// command inputs, each with its own SRAM pin model over one shared memory.
module tb_syn_sram_ctrl;

  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int ptr_m = 0;

  logic        use3 = 1'b0;
  logic [1:0]  req  = 2'b00;
  logic        c_wr    [NP];
  logic [17:0] c_addr  [NP];
  logic [15:0] c_wdata [NP];
  logic [1:0]  c_be    [NP];

  wire [1:0]  req1    = use3 ? 2'b00 : req;
  wire [1:0]  req3    = use3 ? req : 2'b00;
  wire [1:0]  wr_v    = {c_wr[1], c_wr[0]};
  wire [35:0] addr_v  = {c_addr[1], c_addr[0]};
  wire [31:0] wdata_v = {c_wdata[1], c_wdata[0]};
  wire [3:0]  be_v    = {c_be[1], c_be[0]};

  logic [1:0]  ack1, rv1, ben1, ack3, rv3, ben3;
  logic [15:0] rdata1, rdata3;
  logic [17:0] addr1, addr3;
  logic        ce1, oe1, we1, ce3, oe3, we3;
  wire  [15:0] dq1, dq3;

  syn_sram_ctrl #(.ADDR_W(18), .DATA_W(16), .NUM_PORTS(NP), .WAIT_CYCLES(1)) u_dut1 (
    .clk_ir(clk), .rst_ih(rst), .req_i(req1), .wr_i(wr_v), .addr_i(addr_v),
    .wdata_i(wdata_v), .be_i(be_v), .ack_o(ack1), .rdata_o(rdata1),
    .rdata_valid_o(rv1), .sram_dq(dq1), .sram_addr(addr1), .sram_be_n(ben1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1));

  syn_sram_ctrl #(.ADDR_W(18), .DATA_W(16), .NUM_PORTS(NP), .WAIT_CYCLES(3)) u_dut3 (
    .clk_ir(clk), .rst_ih(rst), .req_i(req3), .wr_i(wr_v), .addr_i(addr_v),
    .wdata_i(wdata_v), .be_i(be_v), .ack_o(ack3), .rdata_o(rdata3),
    .rdata_valid_o(rv3), .sram_dq(dq3), .sram_addr(addr3), .sram_be_n(ben3),
    .sram_ce_n(ce3), .sram_oe_n(oe3), .sram_we_n(we3));

  // Observed instance, selected by use3.
  wire [1:0]  m_ack   = use3 ? ack3 : ack1;
  wire [1:0]  m_rv    = use3 ? rv3 : rv1;
  wire [15:0] m_rdata = use3 ? rdata3 : rdata1;
  wire [17:0] m_addr  = use3 ? addr3 : addr1;
  wire [1:0]  m_be_n  = use3 ? ben3 : ben1;
  wire        m_ce_n  = use3 ? ce3 : ce1;
  wire        m_oe_n  = use3 ? oe3 : oe1;
  wire        m_we_n  = use3 ? we3 : we1;
  wire        m_dq_oe = use3 ? u_dut3.dq_oe_q : u_dut1.dq_oe_q;

  // Board SRAM contents; unwritten words read back as 0x1000 + address.
  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return 16'h1000 + 16'(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 16'h1000 + 16'(a);
  endfunction

  task automatic ref_wr(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] w;
    w = ref_rd(a);
    if (be[0]) w[7:0]  = d[7:0];
    if (be[1]) w[15:8] = d[15:8];
    ref_mem[int'(a)] = w;
  endtask

  function automatic int rr_pick(input int ptr, input logic [1:0] pend);
    for (int i = 0; i < NP; i++) begin
      if (pend[(ptr + i) % NP]) return (ptr + i) % NP;
    end
    return 0;
  endfunction

  // SRAM pin models: drive DQ while OE is low, commit enabled lanes while WE is low.
  logic        drv1 = 1'b0, drv3 = 1'b0;
  logic [15:0] dv1 = '0, dv3 = '0;
  assign dq1 = drv1 ? dv1 : 16'bz;
  assign dq3 = drv3 ? dv3 : 16'bz;

  always @(negedge clk) begin
    logic [15:0] w;
    drv1 = !ce1 && !oe1;
    if (drv1) dv1 = sram_rd(addr1);
    if (!ce1 && !we1) begin
      w = sram_rd(addr1);
      if (!ben1[0]) w[7:0]  = dq1[7:0];
      if (!ben1[1]) w[15:8] = dq1[15:8];
      sram_mem[int'(addr1)] = w;
    end
    drv3 = !ce3 && !oe3;
    if (drv3) dv3 = sram_rd(addr3);
    if (!ce3 && !we3) begin
      w = sram_rd(addr3);
      if (!ben3[0]) w[7:0]  = dq3[7:0];
      if (!ben3[1]) w[15:8] = dq3[15:8];
      sram_mem[int'(addr3)] = w;
    end
  end

  // Bus-safety watch: no DQ drive under OE, an idle cycle after every DONE,
  // and never a read strobe directly next to a write strobe.
  logic prev_oe_low = 1'b0, prev_we_low = 1'b0;
  logic [1:0] prev_ack = 2'b00;
  always @(negedge clk) begin
    if (rst) begin
      prev_oe_low = 1'b0;
      prev_we_low = 1'b0;
      prev_ack    = 2'b00;
    end else begin
      if (!m_oe_n && m_dq_oe) viol++;
      if (prev_ack != 2'b00 && !m_ce_n) viol++;
      if ((prev_oe_low && !m_we_n) || (prev_we_low && !m_oe_n)) viol++;
      prev_oe_low = !m_oe_n;
      prev_we_low = !m_we_n;
      prev_ack    = m_ack;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request from port p, issued mid-IDLE; returns at the next IDLE cycle.
  task automatic do_txn(input int p, input logic w_r, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be, input string tag,
                        output logic [15:0] rd);
    int w, k, oe_cnt, we_cnt;
    bit got;
    logic [1:0]  ben_seen, exp_ben;
    logic [15:0] rdata_before;
    w = use3 ? 3 : 1;
    k = 0; oe_cnt = 0; we_cnt = 0; got = 0;
    ben_seen = 2'b11; exp_ben = ~be;
    rdata_before = m_rdata;
    c_wr[p] = w_r; c_addr[p] = a; c_wdata[p] = d; c_be[p] = be;
    req[p] = 1'b1;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (!m_oe_n) oe_cnt++;
      if (!m_we_n) begin
        we_cnt++;
        ben_seen = m_be_n;
      end
      if (m_ack != 2'b00) got = 1;
    end
    check({tag, " latency"}, k, 2 + w);
    check({tag, " ack"}, m_ack, 2'b01 << p);
    check({tag, " rvalid"}, m_rv, w_r ? 2'b00 : (2'b01 << p));
    check({tag, " oe width"}, oe_cnt, w_r ? 0 : w);
    check({tag, " we width"}, we_cnt, w_r ? w : 0);
    check({tag, " addr"}, m_addr, a);
    if (w_r) begin
      check({tag, " be_n"}, ben_seen, exp_ben);
      check({tag, " rdata hold"}, m_rdata, rdata_before);
      ref_wr(a, d, be);
    end
    rd = m_rdata;
    if (!use3) ptr_m = (p + 1) % NP;
    req[p] = 1'b0;
    @(negedge clk);
  endtask

  // Concurrent requests from the ports in mask, commands preset in c_*.
  task automatic run_group(input logic [1:0] mask, input string tag);
    logic [1:0] pend;
    int k, e;
    pend = mask;
    k = 0;
    req = mask;
    while (pend != 2'b00 && k < 40) begin
      @(negedge clk);
      k++;
      if (m_ack != 2'b00) begin
        e = rr_pick(ptr_m, pend);
        check({tag, " grant"}, m_ack, 2'b01 << e);
        ptr_m = (e + 1) % NP;
        if (c_wr[e]) begin
          check({tag, " wr rvalid"}, m_rv, 2'b00);
          ref_wr(c_addr[e], c_wdata[e], c_be[e]);
        end else begin
          check({tag, " rd rvalid"}, m_rv, 2'b01 << e);
          check({tag, " rd data"}, m_rdata, ref_rd(c_addr[e]));
        end
        pend[e] = 1'b0;
        req[e]  = 1'b0;
      end
    end
    check({tag, " all acked"}, pend, 2'b00);
    req = 2'b00;
    @(negedge clk);
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [15:0] rd, exp;
    int k, acks, g;
    logic [1:0] mask;

    vt[0] = '{0, 1'b0, 18'h00123, 16'h0000, 2'b00, 16'hBEEF};
    vt[1] = '{1, 1'b1, 18'h00040, 16'hA5C3, 2'b10, 16'h0000};
    vt[2] = '{0, 1'b0, 18'h00040, 16'h0000, 2'b00, 16'hA540};
    vt[3] = '{1, 1'b1, 18'h00041, 16'h1234, 2'b11, 16'h0000};
    vt[4] = '{0, 1'b0, 18'h00041, 16'h0000, 2'b00, 16'h1234};
    vt[5] = '{0, 1'b1, 18'h00041, 16'hFF00, 2'b01, 16'h0000};
    vt[6] = '{1, 1'b0, 18'h00041, 16'h0000, 2'b00, 16'h1200};
    vt[7] = '{1, 1'b1, 18'h00042, 16'hDEAD, 2'b00, 16'h0000};
    vt[8] = '{0, 1'b0, 18'h00042, 16'h0000, 2'b00, 16'h1042};
    vt[9] = '{1, 1'b0, 18'h00777, 16'h0000, 2'b00, 16'h1777};

    for (int p = 0; p < NP; p++) begin
      c_wr[p] = 1'b0; c_addr[p] = '0; c_wdata[p] = '0; c_be[p] = '0;
    end
    sram_mem[int'(18'h00123)] = 16'hBEEF;
    ref_mem[int'(18'h00123)]  = 16'hBEEF;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst ce_n", m_ce_n, 1'b1);
    check("rst oe_n", m_oe_n, 1'b1);
    check("rst we_n", m_we_n, 1'b1);
    check("rst be_n", m_be_n, 2'b11);
    check("rst addr", m_addr, 18'h0);
    check("rst ack", m_ack, 2'b00);
    check("rst rvalid", m_rv, 2'b00);
    check("rst rdata", m_rdata, 16'h0);
    check("rst dq_oe", m_dq_oe, 1'b0);
    check("rst3 ce_n", ce3, 1'b1);
    rst = 1'b0;
    ptr_m = 0;

    // Directed single transactions, one wait cycle.
    for (int i = 0; i < 10; i++) begin
      do_txn(vt[i].port, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, $sformatf("vec%0d", i), rd);
      if (!vt[i].wr) check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
    end

    // Randomised single transactions against the reference memory.
    for (int i = 0; i < 20; i++) begin
      int p;
      logic w_r;
      logic [17:0] a;
      p   = $urandom_range(0, 1);
      w_r = 1'($urandom_range(0, 1));
      a   = 18'(18'h200 + $urandom_range(0, 7));
      exp = ref_rd(a);
      do_txn(p, w_r, a, 16'($urandom), 2'($urandom_range(0, 3)), $sformatf("rnd%0d", i), rd);
      if (!w_r) check($sformatf("rnd%0d rdata", i), rd, exp);
    end

    // Continuous requests from both ports straight out of reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    c_wr[0] = 1'b0; c_addr[0] = 18'h300;
    c_wr[1] = 1'b0; c_addr[1] = 18'h301;
    req = 2'b11;
    for (int n = 0; n < 6; n++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (m_ack == 2'b00 && k < 20);
      check($sformatf("arb%0d spacing", n), k, (n == 0) ? 3 : 4);
      check($sformatf("arb%0d grant", n), m_ack, 2'b01 << (n % 2));
      g = m_ack[1] ? 1 : 0;
      check($sformatf("arb%0d rdata", n), m_rdata, ref_rd(c_addr[g]));
      ptr_m = (g + 1) % NP;
      c_addr[g] = c_addr[g] + 18'd2;
    end
    req = 2'b00;
    @(negedge clk);

    // Reset in the middle of a write's strobe.
    c_wr[0] = 1'b1; c_addr[0] = 18'h3F000; c_wdata[0] = 16'h5555; c_be[0] = 2'b11;
    req[0] = 1'b1;
    @(negedge clk);
    check("abort setup ce_n", m_ce_n, 1'b0);
    check("abort setup we_n", m_we_n, 1'b1);
    check("abort setup dq_oe", m_dq_oe, 1'b1);
    check("abort setup be_n", m_be_n, 2'b00);
    @(negedge clk);
    check("abort access we_n", m_we_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("abort ce_n", m_ce_n, 1'b1);
    check("abort we_n", m_we_n, 1'b1);
    check("abort be_n", m_be_n, 2'b11);
    check("abort addr", m_addr, 18'h0);
    check("abort dq_oe", m_dq_oe, 1'b0);
    check("abort ack", m_ack, 2'b00);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_ack != 2'b00) acks++;
    end
    check("abort no ack", acks, 0);

    // Read then write back to back; the pointer is back at port 0.
    c_wr[0] = 1'b0; c_addr[0] = 18'h00123;
    c_wr[1] = 1'b1; c_addr[1] = 18'h00123; c_wdata[1] = 16'h0F0F; c_be[1] = 2'b11;
    run_group(2'b11, "turn");
    do_txn(1, 1'b0, 18'h00123, 16'h0, 2'b00, "turn rb", rd);
    check("turn rb rdata", rd, 16'h0F0F);

    // Random concurrent groups checked against the round-robin model.
    for (int i = 0; i < 15; i++) begin
      for (int p = 0; p < NP; p++) begin
        c_wr[p]    = 1'($urandom_range(0, 1));
        c_addr[p]  = 18'(18'h240 + $urandom_range(0, 3));
        c_wdata[p] = 16'($urandom);
        c_be[p]    = 2'($urandom_range(0, 3));
      end
      mask = 2'($urandom_range(1, 3));
      run_group(mask, $sformatf("grp%0d", i));
    end

    // Three wait cycles: one read, one byte write, read-back.
    use3 = 1'b1;
    @(negedge clk);
    exp = ref_rd(18'h00123);
    do_txn(0, 1'b0, 18'h00123, 16'h0, 2'b00, "w3 rd", rd);
    check("w3 rd rdata", rd, exp);
    do_txn(1, 1'b1, 18'h00050, 16'h7E81, 2'b01, "w3 wr", rd);
    do_txn(0, 1'b0, 18'h00050, 16'h0, 2'b00, "w3 rb", rd);
    check("w3 rb rdata", rd, 16'h1081);

    check("bus safety", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syn_sram_ctrl.md
# syn_sram_ctrl

Parametrised multi-port controller for asynchronous SRAM, generalising the 18-bit address / 16-bit data / two-byte-lane SRAM pin interface. It sits between the internal masters and the board SRAM pins. It arbitrates NUM_PORTS requesters round-robin, sequences CE/OE/WE with a programmable access length, drives per-lane byte enables, and owns the DQ tristate.

## Interface
Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 16, data width; multiple of 8; LANES = DATA_W/8
- NUM_PORTS, 2, requester count, 1..8
- WAIT_CYCLES, 1, strobe-active cycles per access; 0 is an elaboration error

Ports:
- clk_ir  in  1  single clock
- rst_ih  in  1  reset; asynchronous, active-high
- req_i  in  NUM_PORTS  request per port; held until ack
- wr_i  in  NUM_PORTS  1=write, 0=read
- addr_i  in  NUM_PORTS*ADDR_W  port p at [p*ADDR_W +: ADDR_W]
- wdata_i  in  NUM_PORTS*DATA_W  write data, same packing
- be_i  in  NUM_PORTS*LANES  write byte enables, active-high; bit0 = byte [7:0]
- ack_o  out  NUM_PORTS  one-cycle completion pulse to the granted port
- rdata_o  out  DATA_W  shared read data, valid with rdata_valid_o
- rdata_valid_o  out  NUM_PORTS  one-cycle read-data pulse to the granted port
- sram_dq  inout  DATA_W  SRAM data bus, tristated when not writing
- sram_addr  out  ADDR_W  SRAM address
- sram_be_n  out  LANES  lane strobes, active-low; bit0 = LB, bit1 = UB
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes

## Operation
FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any req_i is high, grant the highest-priority requester. Latch its wr, addr, wdata and be, then go to SETUP. With no request, stay in IDLE with all strobes high.
- SETUP (1 cycle): ce_n=0, addr driven, oe_n=we_n=1. For a write, DQ drives the latched wdata and be_n=~be. For a read, be_n=all 0. Load the wait counter with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles): read drives oe_n=0; write drives we_n=0. The counter decrements each cycle. When it reaches 0, go to DONE. On the last ACCESS edge, a read captures sram_dq into rdata_o.
- DONE (1 cycle): oe_n=we_n=1, ce_n=0, addr/be_n/DQ held (write hold time). Pulse ack_o[g]; for a read, also pulse rdata_valid_o[g]. Go to IDLE.
- Round robin: pointer reset to 0. After a grant to port k, port (k+1) mod NUM_PORTS becomes highest priority. Requests are scanned upward from the pointer with wrap-around.
- A requester must keep req and its command stable until it sees ack. A requester that is not granted is never acked and waits.
- A write with be=0 runs a full cycle with all lanes disabled and still acks.
- rdata_o holds its last captured value between reads.
- The DQ driver is enabled only in SETUP, ACCESS and DONE of a write. It is never enabled while oe_n=0.

## Timing
- Reset values (asynchronous, immediate): ce_n=oe_n=we_n=1, be_n=all 1, addr=0, DQ high-Z, ack_o=0, rdata_valid_o=0, rdata_o=0, FSM=IDLE, RR pointer=0.
- Reset during a transaction aborts it. No ack is issued, and the bus returns to idle values in the same cycle.
- Latency: request sampled in IDLE cycle T gives SETUP at T+1, ACCESS at T+2..T+1+W, and ack at T+2+W, where W=WAIT_CYCLES.
- Occupancy is 3+W cycles per access. There is at least one IDLE cycle between accesses, so oe_n and the DQ driver are never active together across a read-to-write turnaround.
- Every output is registered. No output changes combinationally from req_i.
- Simultaneous requests resolve by the pointer in the IDLE cycle. Requests that arrive in the DONE cycle are considered in the next IDLE cycle.

## Test plan
- Reset: pulse rst_ih mid-ACCESS of a write. Strobes go to 1 and DQ to Z immediately, with no ack. The next request completes normally.
- Single read, W=1: port0 reads addr 0x00123 with the SRAM model returning 0xBEEF. oe_n is low for exactly 1 cycle, and rdata_o=0xBEEF with rdata_valid_o[0] at T+3.
- Byte write: port1 writes 0xA5C3 with be=2'b10. sram_be_n=2'b01 and we_n is low for W cycles. A read-back from the model gives the upper byte 0xA5 and the lower byte unchanged.
- Arbitration: ports 0 and 1 request continuously from reset with NUM_PORTS=2. Grants alternate 0,1,0,1, with acks spaced exactly 3+W cycles apart.
- Wait states: WAIT_CYCLES=3, one read and one write. The strobe-low width is 3 cycles and ack arrives at T+5.
- Turnaround: read immediately followed by write. A checker asserts that the DQ driver is never enabled while oe_n=0, and that at least one cycle with both strobes high separates the two accesses.
